// File: rtl/freq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | freq_pkg : shared state encoding and defaults for freq_meter          |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package freq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GATE  = 2'd1,
      LATCH = 2'd2
   } state_t;

   localparam int CLK_HZ_DEFAULT = 50_000_000;
   localparam int FREQ_W_DEFAULT = 10;

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_sync : 2-flop synchronizer plus rising-edge detector             |
// | Revision  : 1.0                                                       |
// +----------------------------------------------------------------------+
module edge_sync (
   input  logic clkin,
   input  logic rst_n,
   input  logic i_async,
   output logic o_rise
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= i_async;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign o_rise = r_s2 & ~r_s3;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | freq_meter : counts sigin rising edges over a fixed gate window       |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module freq_meter
   import freq_pkg::*;
#(
   parameter int CLK_HZ      = CLK_HZ_DEFAULT,
   parameter int GATE_CYCLES = CLK_HZ,
   parameter int FREQ_W      = FREQ_W_DEFAULT
) (
   input  logic              clkin,
   input  logic              rst_n,
   input  logic              sigin,
   input  logic              meas_en,
   output logic [FREQ_W-1:0] freq,
   output logic              freq_valid,
   output logic              ovf,
   output logic              busy
);

   localparam int                GCNT_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GCNT_W-1:0] GATE_LAST = GCNT_W'(GATE_CYCLES - 1);
   localparam logic [FREQ_W:0]   EDGE_MAX  = '1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [GCNT_W-1:0]   r_gate_cnt;
   logic [FREQ_W:0]     r_edge_cnt;
   logic [FREQ_W:0]     w_edge_inc;
   logic                w_rise;
   logic                w_gate_end;

   edge_sync u_edge_sync (
      .clkin   (clkin),
      .rst_n   (rst_n),
      .i_async (sigin),
      .o_rise  (w_rise)
   );

   assign w_edge_inc = (w_rise && (r_edge_cnt != EDGE_MAX)) ? r_edge_cnt + 1'b1 : r_edge_cnt;
   assign w_gate_end = (r_state == GATE) && (r_gate_cnt == GATE_LAST);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (meas_en) w_state_nxt = GATE;
         GATE:    if (w_gate_end) w_state_nxt = LATCH;
         LATCH:   w_state_nxt = meas_en ? GATE : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         busy    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         busy    <= (w_state_nxt == GATE);
      end
   end

   // Counters run only in GATE; any other state leaves them cleared, so a rise in LATCH is dropped.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         r_gate_cnt <= '0;
         r_edge_cnt <= '0;
      end else if (r_state == GATE) begin
         r_gate_cnt <= r_gate_cnt + 1'b1;
         r_edge_cnt <= w_edge_inc;
      end else begin
         r_gate_cnt <= '0;
         r_edge_cnt <= '0;
      end
   end

   // The result is captured on the closing gate edge so freq, ovf and freq_valid appear together in LATCH.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         freq       <= '0;
         ovf        <= 1'b0;
         freq_valid <= 1'b0;
      end else begin
         freq_valid <= w_gate_end;
         if (w_gate_end) begin
            freq <= w_edge_inc[FREQ_W] ? '1 : w_edge_inc[FREQ_W-1:0];
            ovf  <= w_edge_inc[FREQ_W];
         end
      end
   end

endmodule
`default_nettype wire
